// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: bubble instruction, skid-buffer state
// and the IF/ID payload layout reused by the later stage registers.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_payload_t;

  // State encoding doubles as the number of held beats.
  function automatic logic [1:0] skid_occupancy(input skid_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage register.
interface if_id_skid_reg_if #(
  parameter int DATA_LENGTH = 32,
  parameter int PC_WIDTH    = 32
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_LENGTH-1:0] ins_in;
  logic [PC_WIDTH-1:0]    pc_in;
  logic [PC_WIDTH-1:0]    pc_plus4_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_LENGTH-1:0] ins_out;
  logic [PC_WIDTH-1:0]    pc_out;
  logic [PC_WIDTH-1:0]    pc_plus4_out;
  logic [1:0]             occupancy;

  modport master (
    output flush, in_valid, ins_in, pc_in, pc_plus4_in, out_ready,
    input  in_ready, out_valid, ins_out, pc_out, pc_plus4_out, occupancy
  );

  modport slave (
    input  flush, in_valid, ins_in, pc_in, pc_plus4_in, out_ready,
    output in_ready, out_valid, ins_out, pc_out, pc_plus4_out, occupancy
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer, flush and NOP bubbles.
// Every output is a flop; in_ready never depends combinationally on out_ready.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                     DATA_LENGTH = 32,
  parameter int                     PC_WIDTH    = 32,
  parameter logic [DATA_LENGTH-1:0] NOP_INSTR   = DATA_LENGTH'(RV_NOP)
) (
  input logic             clk,
  input logic             rst,
  if_id_skid_reg_if.slave bus
);

  skid_state_t            state, state_nxt;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [1:0]             occ_q;
  logic                   in_xfer;
  logic                   out_xfer;

  logic [DATA_LENGTH-1:0] main_ins, skid_ins;
  logic [PC_WIDTH-1:0]    main_pc, main_pc4;
  logic [PC_WIDTH-1:0]    skid_pc, skid_pc4;

  always_comb begin
    in_xfer   = bus.in_valid & in_ready_q & ~bus.flush;
    out_xfer  = out_valid_q & bus.out_ready;
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_xfer) state_nxt = S_FULL;
        S_FULL: begin
          if (in_xfer && !out_xfer)      state_nxt = S_SKID;
          else if (!in_xfer && out_xfer) state_nxt = S_EMPTY;
        end
        S_SKID:  if (out_xfer) state_nxt = S_FULL;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Control stage: handshake flags are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != S_SKID);
      out_valid_q <= (state_nxt != S_EMPTY);
      occ_q       <= skid_occupancy(state_nxt);
    end
  end

  // Main entry: drives the decode side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ins <= NOP_INSTR;
      main_pc  <= '0;
      main_pc4 <= '0;
    end else if (bus.flush) begin
      // Flushing an already empty stage leaves the drained PC visible.
      if (state != S_EMPTY) begin
        main_ins <= NOP_INSTR;
        main_pc  <= '0;
        main_pc4 <= '0;
      end
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            main_ins <= bus.ins_in;
            main_pc  <= bus.pc_in;
            main_pc4 <= bus.pc_plus4_in;
          end
        end
        S_FULL: begin
          if (in_xfer && out_xfer) begin
            main_ins <= bus.ins_in;
            main_pc  <= bus.pc_in;
            main_pc4 <= bus.pc_plus4_in;
          end else if (out_xfer) begin
            main_ins <= NOP_INSTR;
          end
        end
        S_SKID: begin
          if (out_xfer) begin
            main_ins <= skid_ins;
            main_pc  <= skid_pc;
            main_pc4 <= skid_pc4;
          end
        end
        default: ;
      endcase
    end
  end

  // Skid entry: catches the beat that arrives while main is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ins <= NOP_INSTR;
      skid_pc  <= '0;
      skid_pc4 <= '0;
    end else if (bus.flush) begin
      skid_ins <= NOP_INSTR;
      skid_pc  <= '0;
      skid_pc4 <= '0;
    end else if (state == S_FULL && in_xfer && !out_xfer) begin
      skid_ins <= bus.ins_in;
      skid_pc  <= bus.pc_in;
      skid_pc4 <= bus.pc_plus4_in;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.occupancy    = occ_q;
  assign bus.ins_out      = main_ins;
  assign bus.pc_out       = main_pc;
  assign bus.pc_plus4_out = main_pc4;

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline register with valid/ready handshake, two-entry skid buffering, flush and NOP-bubble insertion. It sits between the fetch stage (PC and instruction memory) and the decode stage. Fetch can keep issuing while decode stalls without any combinational ready path crossing the stage. A branch or jump flush empties the stage in one cycle.

Parameters:
DATA_LENGTH, 32, instruction width in bits
PC_WIDTH, 32, program counter width in bits
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0), width DATA_LENGTH

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all held and incoming instructions
in_valid  in  1  fetch presents a beat
in_ready  out  1  stage can accept a beat; registered output
ins_in  in  DATA_LENGTH  fetched instruction
pc_in  in  PC_WIDTH  PC of the instruction
pc_plus4_in  in  PC_WIDTH  PC+4 of the instruction
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode accepts a beat
ins_out  out  DATA_LENGTH  instruction to decode; NOP_INSTR whenever out_valid=0
pc_out  out  PC_WIDTH  PC to decode
pc_plus4_out  out  PC_WIDTH  PC+4 to decode
occupancy  out  2  beats held (0..2)

Behaviour:
- Transfer definitions:
  - in_xfer = in_valid & in_ready & !flush
  - out_xfer = out_valid & out_ready
- Storage: a main register drives all outputs. A skid register is loaded only when main is full and blocked. All outputs are registered; no combinational path from in to out or from out_ready to in_ready.
- Reset (async, rst=1):
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0
  - ins_out=NOP_INSTR, pc_out=0, pc_plus4_out=0
  - skid contents cleared to NOP/0/0
- State EMPTY (occupancy 0):
  - in_xfer: main<=input, go FULL. Latency is 1 cycle from input to output.
- State FULL (occupancy 1):
  - in_xfer & out_xfer: main<=input, stay FULL (full throughput, 1 beat/cycle).
  - in_xfer & !out_xfer: skid<=input, go SKID. in_ready=0 from the next cycle.
  - !in_xfer & out_xfer: main ins<=NOP_INSTR, pc fields hold, go EMPTY.
- State SKID (occupancy 2):
  - in_ready=0.
  - out_xfer: main<=skid, go FULL, in_ready=1 next cycle.
- flush has the highest priority over every transfer:
  - Next state EMPTY.
  - main ins<=NOP_INSTR, pc_out/pc_plus4_out<=0, skid cleared.
  - Any same-cycle input beat is dropped. A same-cycle out_xfer still counts as consumed by decode.
  - in_ready=1 the cycle after.
  - Flush while already EMPTY is a no-op.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush.
- Stable-output rule: while out_valid=1 and out_ready=0, all out payload stays constant.
- in_ready depends only on state. Fetch may assert in_valid regardless of in_ready; a beat is taken only on in_xfer.
- Reset asserted mid-operation: both entries are dropped immediately (async). Release returns to EMPTY with no spurious out_valid.
- occupancy: 0/1/2 encoding of EMPTY/FULL/SKID, registered.

Decomposition:
- Shared package `pipe_pkg` holds:
  - `RV_NOP` constant (32'h0000_0013)
  - state enum `skid_state_t` {S_EMPTY, S_FULL, S_SKID}
  - packed struct `if_id_payload_t` {ins, pc, pc_plus4} at default widths, reused by later ID_EX/EX_MEM successors
- No sub-module is needed. The payload register pair is written inline as a single always_ff for state and one per entry.

Test Plan:
1. Reset then steady stream: out_ready=1, feed pc=0x0,0x4,0x8 with ins 0x00500093,… one per cycle. Required: out_valid rises one cycle after the first beat, pc_out follows 0x0,0x4,0x8 on consecutive cycles, and in_ready stays 1.
2. Decode stall: out_ready=0 with beats pc=0x10 and 0x14 pushed. Required: occupancy reaches 2, in_ready=0 next cycle, and pc_out holds 0x10. When out_ready returns to 1, required order is 0x10, then 0x14, with in_ready=1 after 0x10 leaves.
3. Flush in SKID with a simultaneous in_valid (pc=0x18). Required next cycle: out_valid=0, ins_out=0x00000013, pc_out=0, occupancy=0, in_ready=1. pc=0x18 never appears at the output.
4. Drain: a single beat pc=0x20 with out_ready=1 and no new input. Required: after the beat is consumed, out_valid=0, ins_out=0x00000013, pc_out holds 0x20.
5. Async reset while holding 2 beats: assert rst between clock edges. Required immediately: out_valid=0, occupancy=0, ins_out=NOP. After release, no output until new input.
6. Random in_valid/out_ready (10k cycles) with a scoreboard. Required: in-order, lossless delivery apart from flushes, and out payload stable while stalled.
